tx_fc_credit_gate: RTL and testbench

// - Parametrised TX flow-control credit gate for N_REQ simultaneous TLP requests from the Tx arbiter.
// - Holds the consumed-credit (CC) and credit-limit (CL) registers for P, NP and CPL header/data.
// - Grants requests in priority order. Consumes credits only for granted requests.
// - Sits between the Tx arbiter and the DLL FC-update path, and replaces the fixed 2-command exchange.

---
 rtl/tx_fc_credit_gate_if.sv | 32 +++
 rtl/tx_fc_credit_gate.sv | 134 +++++++++++++
 tb/tb_tx_fc_credit_gate.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/tx_fc_credit_gate_if.sv
// Request/flow-control bundle between the Tx arbiter (master) and the credit gate (slave).
// A request slot is accepted only in a cycle where req_valid[i] and grant[i] are both high.
// grant is a combinational, same-cycle answer, so the master must not make req_* depend on grant.
interface tx_fc_credit_gate_if #(
    parameter int N_REQ         = 2,
    parameter int FC_HDR_WIDTH  = 12,
    parameter int FC_DATA_WIDTH = 16,
    parameter int PTLP_WIDTH    = 10
);
    logic [N_REQ-1:0]                 req_valid;
    logic [N_REQ-1:0][1:0]            req_type;
    logic [N_REQ-1:0][PTLP_WIDTH-1:0] req_data_cred;
    logic [N_REQ-1:0]                 grant;
    logic                             fc_init_valid;
    logic                             fc_update_valid;
    logic [1:0]                       fc_type;
    logic [FC_HDR_WIDTH-1:0]          fc_hdr_limit;
    logic [FC_DATA_WIDTH-1:0]         fc_data_limit;
    logic                             fc_ready;

    modport master (
        output req_valid, req_type, req_data_cred,
        output fc_init_valid, fc_update_valid, fc_type, fc_hdr_limit, fc_data_limit,
        input  grant, fc_ready
    );

    modport slave (
        input  req_valid, req_type, req_data_cred,
        input  fc_init_valid, fc_update_valid, fc_type, fc_hdr_limit, fc_data_limit,
        output grant, fc_ready
    );
endinterface

// File: rtl/tx_fc_credit_gate.sv
// TX flow-control credit gate: holds CC/CL per P/NP/CPL header and data field and grants
// the longest fitting prefix of the prioritised request slots each cycle.
module tx_fc_credit_gate #(
    parameter int N_REQ         = 2,
    parameter int FC_HDR_WIDTH  = 12,
    parameter int FC_DATA_WIDTH = 16,
    parameter int PTLP_WIDTH    = 10
) (
    input  logic                clk,
    input  logic                rst,
    tx_fc_credit_gate_if.slave  fc_if,
    output logic                o_dbg_state
);
    typedef enum logic {ST_INIT = 1'b0, ST_ACTIVE = 1'b1} state_t;

    localparam logic [FC_HDR_WIDTH-1:0]  HDR_ONE   = FC_HDR_WIDTH'(1);
    localparam logic [FC_HDR_WIDTH-1:0]  HDR_HALF  = FC_HDR_WIDTH'(1) << (FC_HDR_WIDTH - 1);
    localparam logic [FC_DATA_WIDTH-1:0] DATA_HALF = FC_DATA_WIDTH'(1) << (FC_DATA_WIDTH - 1);

    state_t                   r_state;
    state_t                   w_state_next;
    logic [2:0]               r_init;
    logic [2:0]               w_init_next;
    logic [2:0]               r_inf_hdr;
    logic [2:0]               r_inf_data;
    logic [FC_HDR_WIDTH-1:0]  r_cc_hdr   [3];
    logic [FC_DATA_WIDTH-1:0] r_cc_data  [3];
    logic [FC_HDR_WIDTH-1:0]  r_cl_hdr   [3];
    logic [FC_DATA_WIDTH-1:0] r_cl_data  [3];
    logic [FC_HDR_WIDTH-1:0]  w_cc_hdr_next  [3];
    logic [FC_DATA_WIDTH-1:0] w_cc_data_next [3];
    logic [N_REQ-1:0]         w_grant;
    logic                     w_gate_open;
    logic                     w_fc_type_ok;

    assign w_gate_open  = (r_state == ST_ACTIVE) && !rst;
    assign w_fc_type_ok = (fc_if.fc_type != 2'd3);
    assign fc_if.grant    = w_grant;
    assign fc_if.fc_ready = (r_state == ST_ACTIVE);
    assign o_dbg_state    = r_state;

    always_comb begin
        w_state_next = r_state;
        w_init_next  = r_init;
        if (r_state == ST_INIT) begin
            if (fc_if.fc_init_valid && w_fc_type_ok) begin
                w_init_next[fc_if.fc_type] = 1'b1;
            end
            if (&w_init_next) begin
                w_state_next = ST_ACTIVE;
            end
        end
    end

    // Running per-type sums walk the slots in priority order; the first refusal freezes the
    // CC snapshot so only the granted prefix is consumed.
    always_comb begin
        logic [FC_HDR_WIDTH-1:0]  acc_hdr  [3];
        logic [FC_DATA_WIDTH-1:0] acc_data [3];
        logic [FC_HDR_WIDTH-1:0]  diff_hdr;
        logic [FC_DATA_WIDTH-1:0] diff_data;
        logic [1:0]               t;
        logic                     fit;
        logic                     blocked;
        w_grant = '0;
        blocked = 1'b0;
        diff_hdr  = '0;
        diff_data = '0;
        for (int k = 0; k < 3; k++) begin
            acc_hdr[k]        = r_cc_hdr[k];
            acc_data[k]       = r_cc_data[k];
            w_cc_hdr_next[k]  = r_cc_hdr[k];
            w_cc_data_next[k] = r_cc_data[k];
        end
        for (int i = 0; i < N_REQ; i++) begin
            t   = 2'd0;
            fit = 1'b0;
            if (fc_if.req_valid[i]) begin
                if (fc_if.req_type[i] != 2'd3) begin
                    t           = fc_if.req_type[i];
                    acc_hdr[t]  = acc_hdr[t] + HDR_ONE;
                    acc_data[t] = acc_data[t] + FC_DATA_WIDTH'(fc_if.req_data_cred[i]);
                    diff_hdr    = r_cl_hdr[t] - acc_hdr[t];
                    diff_data   = r_cl_data[t] - acc_data[t];
                    fit = (r_inf_hdr[t]  || (diff_hdr  <= HDR_HALF)) &&
                          (r_inf_data[t] || (diff_data <= DATA_HALF));
                end
                if (w_gate_open && !blocked && fit) begin
                    w_grant[i]        = 1'b1;
                    w_cc_hdr_next[t]  = acc_hdr[t];
                    w_cc_data_next[t] = acc_data[t];
                end else begin
                    blocked = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_INIT;
            r_init     <= '0;
            r_inf_hdr  <= '0;
            r_inf_data <= '0;
            for (int k = 0; k < 3; k++) begin
                r_cc_hdr[k]  <= '0;
                r_cc_data[k] <= '0;
                r_cl_hdr[k]  <= '0;
                r_cl_data[k] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            r_init  <= w_init_next;
            for (int k = 0; k < 3; k++) begin
                r_cc_hdr[k]  <= w_cc_hdr_next[k];
                r_cc_data[k] <= w_cc_data_next[k];
            end
            if (r_state == ST_INIT && fc_if.fc_init_valid && w_fc_type_ok) begin
                r_cl_hdr[fc_if.fc_type]   <= fc_if.fc_hdr_limit;
                r_cl_data[fc_if.fc_type]  <= fc_if.fc_data_limit;
                r_inf_hdr[fc_if.fc_type]  <= (fc_if.fc_hdr_limit == '0);
                r_inf_data[fc_if.fc_type] <= (fc_if.fc_data_limit == '0);
            end else if (r_state == ST_ACTIVE && fc_if.fc_update_valid && w_fc_type_ok) begin
                // Infinite fields keep their zero limit for the life of the link.
                if (!r_inf_hdr[fc_if.fc_type]) begin
                    r_cl_hdr[fc_if.fc_type] <= fc_if.fc_hdr_limit;
                end
                if (!r_inf_data[fc_if.fc_type]) begin
                    r_cl_data[fc_if.fc_type] <= fc_if.fc_data_limit;
                end
            end
        end
    end
endmodule

// File: tb/tb_tx_fc_credit_gate.sv
// Directed bench for tx_fc_credit_gate: each step pushes the expected {fc_ready, grant}
// and pops it for comparison mid-cycle, before the edge that commits the step.
module tb_tx_fc_credit_gate;
  localparam logic [1:0] T_P   = 2'd0;
  localparam logic [1:0] T_NP  = 2'd1;
  localparam logic [1:0] T_CPL = 2'd2;
  localparam logic [1:0] T_RSV = 2'd3;

  logic clk;
  logic rst;
  logic dbg_state;
  int   n_vec;
  int   n_err;
  int   cc_h;
  int   target;
  logic [2:0] exp_q[$];

  tx_fc_credit_gate_if #(.N_REQ(2), .FC_HDR_WIDTH(12), .FC_DATA_WIDTH(16), .PTLP_WIDTH(10)) fc_if ();

  tx_fc_credit_gate #(.N_REQ(2), .FC_HDR_WIDTH(12), .FC_DATA_WIDTH(16), .PTLP_WIDTH(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .fc_if       (fc_if.slave),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic set_fc(input logic init, input logic upd, input logic [1:0] t,
                        input logic [11:0] h, input logic [15:0] d);
    fc_if.fc_init_valid   = init;
    fc_if.fc_update_valid = upd;
    fc_if.fc_type         = t;
    fc_if.fc_hdr_limit    = h;
    fc_if.fc_data_limit   = d;
  endtask

  task automatic step(input string tag, input logic [1:0] v,
                      input logic [1:0] t0, input logic [1:0] t1,
                      input logic [9:0] c0, input logic [9:0] c1,
                      input logic er, input logic [1:0] eg);
    logic [2:0] exp_v;
    logic [2:0] obs_v;
    fc_if.req_valid        = v;
    fc_if.req_type[0]      = t0;
    fc_if.req_type[1]      = t1;
    fc_if.req_data_cred[0] = c0;
    fc_if.req_data_cred[1] = c1;
    exp_q.push_back({er, eg});
    #4;
    exp_v = exp_q.pop_front();
    obs_v = {fc_if.fc_ready, fc_if.grant};
    n_vec++;
    assert (obs_v === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed ready/grant=%b required %b", tag, obs_v, exp_v);
    end
    @(posedge clk);
    #1;
    fc_if.fc_init_valid   = 1'b0;
    fc_if.fc_update_valid = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    fc_if.req_valid     = '0;
    fc_if.req_type      = '0;
    fc_if.req_data_cred = '0;
    set_fc(1'b0, 1'b0, T_P, 12'd0, 16'd0);
    @(posedge clk);
    #1;

    step("rst_hold",   2'b11, T_P, T_P, 10'd1, 10'd1, 1'b0, 2'b00);
    step("rst_hold2",  2'b11, T_NP, T_P, 10'd1, 10'd1, 1'b0, 2'b00);
    rst = 1'b0;
    step("post_rst",   2'b11, T_P, T_P, 10'd1, 10'd1, 1'b0, 2'b00);
    set_fc(1'b0, 1'b1, T_P, 12'd4, 16'd8);
    step("upd_in_init", 2'b00, T_P, T_P, 10'd0, 10'd0, 1'b0, 2'b00);
    set_fc(1'b1, 1'b0, T_P, 12'd4, 16'd8);
    step("init_p",     2'b11, T_P, T_P, 10'd1, 10'd1, 1'b0, 2'b00);
    set_fc(1'b1, 1'b0, T_NP, 12'd0, 16'd0);
    step("init_np",    2'b11, T_NP, T_NP, 10'd1, 10'd1, 1'b0, 2'b00);
    set_fc(1'b1, 1'b0, T_CPL, 12'd2, 16'd16);
    step("init_cpl",   2'b11, T_P, T_P, 10'd1, 10'd1, 1'b0, 2'b00);
    step("ready_idle", 2'b00, T_P, T_P, 10'd0, 10'd0, 1'b1, 2'b00);

    // NP is infinite in both fields
    for (int i = 0; i < 3; i++)
      step("np_inf", 2'b11, T_NP, T_NP, 10'd1000, 10'd1000, 1'b1, 2'b11);
    set_fc(1'b0, 1'b1, T_NP, 12'd1, 16'd1);
    step("np_upd_ign", 2'b11, T_NP, T_NP, 10'd1000, 10'd1000, 1'b1, 2'b11);
    step("np_upd_ign2", 2'b11, T_NP, T_NP, 10'd1000, 10'd1000, 1'b1, 2'b11);

    // P: limit hdr 4 / data 8
    step("p_fill",     2'b11, T_P, T_P, 10'd4, 10'd4, 1'b1, 2'b11);
    step("p_exhaust",  2'b01, T_P, T_P, 10'd1, 10'd0, 1'b1, 2'b00);
    set_fc(1'b1, 1'b0, T_P, 12'd0, 16'd0);
    step("p_init_ign", 2'b01, T_P, T_P, 10'd1, 10'd0, 1'b1, 2'b00);
    step("p_init_ign2", 2'b01, T_P, T_P, 10'd1, 10'd0, 1'b1, 2'b00);
    set_fc(1'b0, 1'b1, T_P, 12'd4, 16'd12);
    step("p_upd_same", 2'b01, T_P, T_P, 10'd1, 10'd0, 1'b1, 2'b00);
    step("p_retry",    2'b01, T_P, T_P, 10'd1, 10'd0, 1'b1, 2'b01);

    // strict priority order
    step("order_blk",  2'b11, T_CPL, T_P, 10'd20, 10'd1, 1'b1, 2'b00);
    step("order_skip", 2'b10, T_CPL, T_P, 10'd20, 10'd1, 1'b1, 2'b10);
    step("rsv_blk",    2'b11, T_RSV, T_NP, 10'd1, 10'd1, 1'b1, 2'b00);
    step("rsv_one",    2'b01, T_RSV, T_NP, 10'd1, 10'd1, 1'b1, 2'b00);

    // walk CC_hdr[P] from 4 up to 4094 with zero-data grants
    cc_h = 4;
    while (cc_h < 4094) begin
      target = (cc_h + 2000 > 4094) ? 4094 : cc_h + 2000;
      set_fc(1'b0, 1'b1, T_P, 12'(target), 16'd12);
      step("walk_upd", 2'b00, T_P, T_P, 10'd0, 10'd0, 1'b1, 2'b00);
      while (cc_h + 2 <= target) begin
        step("walk_fill", 2'b11, T_P, T_P, 10'd0, 10'd0, 1'b1, 2'b11);
        cc_h += 2;
      end
    end
    set_fc(1'b0, 1'b1, T_P, 12'd1, 16'd12);
    step("wrap_upd",   2'b00, T_P, T_P, 10'd0, 10'd0, 1'b1, 2'b00);
    step("wrap_a",     2'b11, T_P, T_P, 10'd0, 10'd0, 1'b1, 2'b11);
    step("wrap_b",     2'b01, T_P, T_P, 10'd0, 10'd0, 1'b1, 2'b01);
    step("wrap_full",  2'b01, T_P, T_P, 10'd0, 10'd0, 1'b1, 2'b00);

    // reset mid-stream
    step("pre_rst",    2'b11, T_NP, T_NP, 10'd5, 10'd5, 1'b1, 2'b11);
    rst = 1'b1;
    step("rst_mid",    2'b11, T_NP, T_NP, 10'd5, 10'd5, 1'b1, 2'b00);
    step("rst_mid2",   2'b11, T_NP, T_NP, 10'd5, 10'd5, 1'b0, 2'b00);
    rst = 1'b0;
    step("rst_init",   2'b11, T_P, T_NP, 10'd1, 10'd1, 1'b0, 2'b00);
    set_fc(1'b1, 1'b0, T_P, 12'd1, 16'd8);
    step("reinit_p",   2'b00, T_P, T_P, 10'd0, 10'd0, 1'b0, 2'b00);
    set_fc(1'b1, 1'b0, T_NP, 12'd1, 16'd1);
    step("reinit_np",  2'b00, T_P, T_P, 10'd0, 10'd0, 1'b0, 2'b00);
    set_fc(1'b1, 1'b0, T_CPL, 12'd2, 16'd16);
    step("reinit_cpl", 2'b00, T_P, T_P, 10'd0, 10'd0, 1'b0, 2'b00);
    step("cc_clr_p",   2'b01, T_P, T_P, 10'd8, 10'd0, 1'b1, 2'b01);
    step("np_limited", 2'b11, T_NP, T_NP, 10'd1, 10'd0, 1'b1, 2'b01);
    step("rsv_never",  2'b01, T_RSV, T_P, 10'd0, 10'd0, 1'b1, 2'b00);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
